// File: rtl/dmem_arbiter_if.sv
// Requester-side port bundle for the data memory arbiter: one instance per
// master (CPU load/store unit, ASCON accelerator).
interface dmem_arbiter_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  size;
   logic        sign;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, wdata, size, sign,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata, size, sign,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single data memory port between two requesters, checks range and
// alignment, and returns registered load data or an error to the winner.
//
// state  | meaning
// IDLE   | sample requests, pick winner, latch request and error flag
// ACCESS | drive memory for one cycle, pulse gnt, capture load data
// RESP   | pulse rvalid with rdata/err to the owner
module dmem_arbiter #(
   parameter logic [31:0] ADDR_BASE  = 32'h1000_0000,
   parameter int          ADDR_BITS  = 16,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   dmem_arbiter_if.slave     m0,
   dmem_arbiter_if.slave     m1,
   output logic [31:0]       mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_memwrite,
   output logic              mem_memread,
   output logic [1:0]        mem_byte_size,
   output logic              mem_sign_ext,
   input  logic [31:0]       mem_read_data,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        last_owner_q;
   logic        owner_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic        any_req;
   logic        winner;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [1:0]  sel_size;
   logic        sel_sign;
   logic        sel_err;
   logic        in_access;
   logic        in_resp;
   logic [31:0] resp_data;

   assign any_req = m0.req | m1.req;

   // On a tie the requester that did not own the previous access wins.
   always_comb begin
      winner = m1.req;
      if (m0.req && m1.req) begin
         winner = FIXED_PRIO ? 1'b0 : ~last_owner_q;
      end
   end

   assign sel_we    = winner ? m1.we    : m0.we;
   assign sel_addr  = winner ? m1.addr  : m0.addr;
   assign sel_wdata = winner ? m1.wdata : m0.wdata;
   assign sel_size  = winner ? m1.size  : m0.size;
   assign sel_sign  = winner ? m1.sign  : m0.sign;

   always_comb begin
      sel_err = 1'b0;
      if (sel_size == 2'b11)                              sel_err = 1'b1;
      if (sel_size == 2'b01 && sel_addr[0])               sel_err = 1'b1;
      if (sel_size == 2'b10 && sel_addr[1:0] != 2'b00)    sel_err = 1'b1;
      if ((sel_addr >> ADDR_BITS) != (ADDR_BASE >> ADDR_BITS)) sel_err = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         size_q       <= 2'b00;
         sign_q       <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && any_req) begin
            owner_q      <= winner;
            last_owner_q <= winner;
            we_q         <= sel_we;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            size_q       <= sel_size;
            sign_q       <= sel_sign;
            err_q        <= sel_err;
         end
         if (state_q == ACCESS && !we_q && !err_q) begin
            rdata_q <= mem_read_data;
         end
      end
   end

   assign in_access = (state_q == ACCESS);
   assign in_resp   = (state_q == RESP);
   assign busy      = (state_q != IDLE);

   assign mem_address    = in_access ? addr_q  : 32'h0;
   assign mem_write_data = in_access ? wdata_q : 32'h0;
   assign mem_byte_size  = in_access ? size_q  : 2'b00;
   assign mem_sign_ext   = in_access & sign_q;
   assign mem_memwrite   = in_access & we_q & ~err_q;
   assign mem_memread    = in_access & ~we_q & ~err_q;

   assign resp_data = (we_q | err_q) ? 32'h0 : rdata_q;

   assign m0.gnt    = in_access & ~owner_q;
   assign m1.gnt    = in_access & owner_q;
   assign m0.rvalid = in_resp & ~owner_q;
   assign m1.rvalid = in_resp & owner_q;
   assign m0.rdata  = m0.rvalid ? resp_data : 32'h0;
   assign m1.rdata  = m1.rvalid ? resp_data : 32'h0;
   assign m0.err    = m0.rvalid & err_q;
   assign m1.err    = m1.rvalid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses,
// a forked monitor pops and compares them whenever rvalid is seen.
module tb_dmem_arbiter;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   dmem_arbiter_if m0_if ();
   dmem_arbiter_if m1_if ();
   dmem_arbiter_if f0_if ();
   dmem_arbiter_if f1_if ();

   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_memwrite, mem_memread, mem_sign_ext, busy;
   logic [1:0]  mem_byte_size;

   logic [31:0] fp_address, fp_write_data;
   logic        fp_memwrite, fp_memread, fp_sign_ext, fp_busy;
   logic [1:0]  fp_byte_size;

   dmem_arbiter dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .m0             (m0_if),
      .m1             (m1_if),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_memwrite   (mem_memwrite),
      .mem_memread    (mem_memread),
      .mem_byte_size  (mem_byte_size),
      .mem_sign_ext   (mem_sign_ext),
      .mem_read_data  (mem_read_data),
      .busy           (busy)
   );

   dmem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
      .clock          (clock),
      .reset_n        (reset_n),
      .m0             (f0_if),
      .m1             (f1_if),
      .mem_address    (fp_address),
      .mem_write_data (fp_write_data),
      .mem_memwrite   (fp_memwrite),
      .mem_memread    (fp_memread),
      .mem_byte_size  (fp_byte_size),
      .mem_sign_ext   (fp_sign_ext),
      .mem_read_data  (32'h0),
      .busy           (fp_busy)
   );

   // Little-endian 64 KB memory: combinational read, write on the clock edge.
   logic [7:0]  mem [0:65535] = '{default: 8'h00};
   logic [15:0] a0, a1, a2, a3;
   assign a0 = mem_address[15:0];
   assign a1 = a0 + 16'd1;
   assign a2 = a0 + 16'd2;
   assign a3 = a0 + 16'd3;

   always @(posedge clock) begin
      if (mem_memwrite) begin
         mem[a0] <= mem_write_data[7:0];
         if (mem_byte_size != 2'b00) mem[a1] <= mem_write_data[15:8];
         if (mem_byte_size == 2'b10) begin
            mem[a2] <= mem_write_data[23:16];
            mem[a3] <= mem_write_data[31:24];
         end
      end
   end

   always_comb begin
      mem_read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
      if (mem_byte_size == 2'b00)
         mem_read_data = mem_sign_ext ? {{24{mem[a0][7]}}, mem[a0]} : {24'h0, mem[a0]};
      else if (mem_byte_size == 2'b01)
         mem_read_data = mem_sign_ext ? {{16{mem[a1][7]}}, mem[a1], mem[a0]}
                                      : {16'h0, mem[a1], mem[a0]};
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   gnt_last[2];
   int   log_port[$];
   int   log_cyc[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chkb(string name, logic act, logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(int p, logic req, logic we, logic [31:0] addr,
                        logic [31:0] wdata, logic [1:0] size, logic sign);
      if (p == 0) begin
         m0_if.req = req; m0_if.we = we; m0_if.addr = addr;
         m0_if.wdata = wdata; m0_if.size = size; m0_if.sign = sign;
      end else begin
         m1_if.req = req; m1_if.we = we; m1_if.addr = addr;
         m1_if.wdata = wdata; m1_if.size = size; m1_if.sign = sign;
      end
   endtask

   task automatic mon_port(int p, logic g, logic rv, logic [31:0] rd, logic e);
      exp_t x;
      if (g) begin
         gnt_last[p] = cyc;
         log_port.push_back(p);
         log_cyc.push_back(cyc);
      end
      if (rv) begin
         if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rvalid m%0d: got rvalid=1 expected none (cycle %0d)", p, cyc);
         end else begin
            x = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("m%0d_rdata", p), rd, x.rdata);
            chkb($sformatf("m%0d_err", p), e, x.err);
            chk($sformatf("m%0d_rvalid_after_gnt", p), 32'(cyc - gnt_last[p]), 32'd1);
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clock);
         mon_port(0, m0_if.gnt, m0_if.rvalid, m0_if.rdata, m0_if.err);
         mon_port(1, m1_if.gnt, m1_if.rvalid, m1_if.rdata, m1_if.err);
      end
   endtask

   task automatic issue(int p, logic we, logic [31:0] addr, logic [31:0] wdata,
                        logic [1:0] size, logic sign, logic [31:0] exp_rd,
                        logic exp_err, int exp_lat, bit keep);
      exp_t e;
      int   t0;
      logic got;
      @(posedge clock); #1;
      drive(p, 1'b1, we, addr, wdata, size, sign);
      t0 = cyc;
      e.rdata = exp_rd;
      e.err   = exp_err;
      if (p == 0) q0.push_back(e); else q1.push_back(e);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clock);
         got = (p == 0) ? m0_if.gnt : m1_if.gnt;
      end
      chkb($sformatf("m%0d_gnt_seen @%h", p, addr), got, 1'b1);
      if (got) begin
         if (exp_lat > 0) chk("gnt_latency", 32'(cyc - t0), 32'(exp_lat));
         chkb("mem_memwrite", mem_memwrite, we & ~exp_err);
         chkb("mem_memread", mem_memread, ~we & ~exp_err);
         if (!exp_err) begin
            chk("mem_byte_size", 32'(mem_byte_size), 32'(size));
            chk("mem_address", mem_address, addr);
         end
      end
      if (!keep) begin
         @(posedge clock); #1;
         drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clock); #1;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      int   t0, ng, g1, g2, n0, n1;
      logic got;
      exp_t e;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      f0_if.req = 1'b0; f0_if.we = 1'b0; f0_if.addr = 32'h1000_0000;
      f0_if.wdata = 32'h0; f0_if.size = 2'b10; f0_if.sign = 1'b0;
      f1_if.req = 1'b0; f1_if.we = 1'b0; f1_if.addr = 32'h1000_0004;
      f1_if.wdata = 32'h0; f1_if.size = 2'b10; f1_if.sign = 1'b0;
      fork
         monitor();
      join_none

      // Reset: a pending request must not be granted while reset is low.
      m0_if.req = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_m0_gnt", m0_if.gnt, 1'b0);
      chkb("rst_memread", mem_memread, 1'b0);
      chkb("rst_memwrite", mem_memwrite, 1'b0);
      chk("rst_mem_address", mem_address, 32'h0);
      chkb("rst_m0_rvalid", m0_if.rvalid, 1'b0);
      chk("rst_m0_rdata", m0_if.rdata, 32'h0);
      chkb("rst_m1_err", m1_if.err, 1'b0);
      chkb("rst_fp_busy", fp_busy, 1'b0);
      m0_if.req = 1'b0;
      reset_n = 1'b1;

      // Basic store/load and sign extension
      issue(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         1'b0, 1, 0);
      issue(0, 1'b0, 32'h1000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1, 0);
      issue(0, 1'b1, 32'h1000_0021, 32'h0000_0080, 2'b00, 1'b0, 32'h0,         1'b0, 1, 0);
      issue(0, 1'b0, 32'h1000_0021, 32'h0,         2'b00, 1'b1, 32'hFFFF_FF80, 1'b0, 1, 0);
      issue(0, 1'b0, 32'h1000_0021, 32'h0,         2'b00, 1'b0, 32'h0000_0080, 1'b0, 1, 0);
      issue(0, 1'b0, 32'h1000_0020, 32'h0,         2'b01, 1'b1, 32'hFFFF_8000, 1'b0, 1, 0);
      issue(1, 1'b0, 32'h1000_0020, 32'h0,         2'b01, 1'b0, 32'h0000_8000, 1'b0, 1, 0);
      issue(1, 1'b0, 32'h1000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1, 0);

      // Error responses and window boundaries
      issue(0, 1'b0, 32'h1000_0002, 32'h0,         2'b10, 1'b0, 32'h0, 1'b1, 1, 0);
      issue(1, 1'b1, 32'h1000_0001, 32'h0000_FFFF, 2'b01, 1'b0, 32'h0, 1'b1, 1, 0);
      issue(0, 1'b0, 32'h1000_0000, 32'h0,         2'b11, 1'b0, 32'h0, 1'b1, 1, 0);
      issue(1, 1'b0, 32'h2000_0000, 32'h0,         2'b10, 1'b0, 32'h0, 1'b1, 1, 0);
      issue(0, 1'b0, 32'h1001_0000, 32'h0,         2'b10, 1'b0, 32'h0, 1'b1, 1, 0);
      issue(0, 1'b0, 32'h1000_0000, 32'h0,         2'b10, 1'b0, 32'h0, 1'b0, 1, 0);
      issue(1, 1'b0, 32'h1000_FFFC, 32'h0,         2'b10, 1'b0, 32'h0, 1'b0, 1, 0);

      // Reset during ACCESS of a store: no commit, no response
      @(posedge clock); #1;
      drive(0, 1'b1, 1'b1, 32'h1000_0040, 32'h1234_5678, 2'b10, 1'b0);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clock);
         got = m0_if.gnt;
      end
      chkb("rma_gnt_seen", got, 1'b1);
      chkb("rma_memwrite_before", mem_memwrite, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chkb("rma_memwrite_async", mem_memwrite, 1'b0);
      chkb("rma_busy", busy, 1'b0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      repeat (4) @(posedge clock);
      issue(0, 1'b0, 32'h1000_0040, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0, 1, 0);

      // m1 holds the same request for 6 cycles: two grants at T+1 and T+4
      e.rdata = 32'hDEAD_BEEF;
      e.err   = 1'b0;
      q1.push_back(e);
      q1.push_back(e);
      @(posedge clock); #1;
      drive(1, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 2'b10, 1'b0);
      t0 = cyc; ng = 0; g1 = 0; g2 = 0;
      repeat (6) begin
         @(negedge clock);
         if (m1_if.gnt) begin
            ng++;
            if (ng == 1) g1 = cyc - t0;
            else if (ng == 2) g2 = cyc - t0;
         end
      end
      @(posedge clock); #1;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      chk("hold_gnt_count", 32'(ng), 32'd2);
      chk("hold_gnt1_offset", 32'(g1), 32'd1);
      chk("hold_gnt2_offset", 32'(g2), 32'd4);

      // Both requesters from reset: round-robin m0, m1, m0, m1
      pulse_reset();
      log_port.delete();
      log_cyc.delete();
      fork
         begin
            issue(0, 1'b1, 32'h1000_0100, 32'hA0A0_0001, 2'b10, 1'b0, 32'h0, 1'b0, 1, 1);
            issue(0, 1'b1, 32'h1000_0104, 32'hA0A0_0002, 2'b10, 1'b0, 32'h0, 1'b0, 0, 0);
         end
         begin
            issue(1, 1'b1, 32'h1000_0200, 32'hB0B0_0001, 2'b10, 1'b0, 32'h0, 1'b0, 0, 1);
            issue(1, 1'b1, 32'h1000_0204, 32'hB0B0_0002, 2'b10, 1'b0, 32'h0, 1'b0, 0, 0);
         end
      join
      chk("rr_grant_count", 32'(log_port.size()), 32'd4);
      if (log_port.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_owner_%0d", i), 32'(log_port[i]), 32'(i % 2));
            if (i > 0) chk($sformatf("rr_spacing_%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);
         end
      end
      issue(1, 1'b0, 32'h1000_0204, 32'h0, 2'b10, 1'b0, 32'hB0B0_0002, 1'b0, 1, 0);
      issue(0, 1'b0, 32'h1000_0100, 32'h0, 2'b10, 1'b0, 32'hA0A0_0001, 1'b0, 1, 0);

      // Fixed priority: m0 wins every tie while it keeps requesting
      pulse_reset();
      @(posedge clock); #1;
      f0_if.req = 1'b1;
      f1_if.req = 1'b1;
      n0 = 0; n1 = 0;
      repeat (12) begin
         @(negedge clock);
         if (f0_if.gnt) n0++;
         if (f1_if.gnt) n1++;
      end
      chk("fp_m0_grants", 32'(n0), 32'd4);
      chk("fp_m1_grants", 32'(n1), 32'd0);
      @(posedge clock); #1;
      f0_if.req = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clock);
         got = f1_if.gnt;
      end
      chkb("fp_m1_served_after_m0_drops", got, 1'b1);
      @(posedge clock); #1;
      f1_if.req = 1'b0;

      repeat (5) @(posedge clock);
      chk("m0_queue_drained", 32'(q0.size()), 32'd0);
      chk("m1_queue_drained", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the summary by %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the 64 KB data memory. It shares the single memory port between the CPU load/store unit (m0) and the ASCON accelerator (m1) using round-robin arbitration. It checks address range and alignment, drives the memory control signals for exactly one cycle per access, and returns registered read data or an error response to the requester that won.

## Interface
- `ADDR_BASE`, default 32'h1000_0000: base of the data memory window.
- `ADDR_BITS`, default 16: window size is 2^ADDR_BITS bytes.
- `FIXED_PRIO`, default 0: 1 means m0 always wins a tie; 0 means round-robin.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mX_req`  in  1  request valid (X = 0, 1). Held with all fields stable until `mX_gnt`.
- `mX_we`  in  1  1 = store, 0 = load.
- `mX_addr`  in  32  byte address.
- `mX_wdata`  in  32  store data, LSB-aligned.
- `mX_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `mX_sign`  in  1  sign-extend load (LB/LH).
- `mX_gnt`  out  1  one-cycle pulse: request accepted.
- `mX_rvalid`  out  1  one-cycle pulse: response valid.
- `mX_rdata`  out  32  load data. 0 for stores and errors.
- `mX_err`  out  1  qualified by `mX_rvalid`: access rejected.
- `mem_address`  out  32  to data memory.
- `mem_write_data`  out  32  to data memory.
- `mem_memwrite`  out  1  to data memory.
- `mem_memread`  out  1  to data memory.
- `mem_byte_size`  out  2  to data memory.
- `mem_sign_ext`  out  1  to data memory.
- `mem_read_data`  in  32  combinational read data from data memory.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP. Transitions: IDLE→ACCESS when any `mX_req` is high; ACCESS→RESP always; RESP→IDLE always.
- Requests are sampled only in IDLE. In IDLE, at the clock edge:
  - The winner is selected.
  - All of the winner's fields are latched into a request register.
  - The owner id is latched.
  - The error flag is computed and latched.
- Arbitration:
  - Only one requester → that requester wins.
  - Both requesting, `FIXED_PRIO`=1 → m0 wins.
  - Both requesting, `FIXED_PRIO`=0 → the requester other than `last_owner` wins.
  - `last_owner` is updated on each grant. Its reset value is 1, so m0 wins the first tie.
- The error flag is set when any of these holds:
  - `size`=11.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `addr[31:ADDR_BITS]` ≠ `ADDR_BASE[31:ADDR_BITS]`.
- ACCESS:
  - `mX_gnt` of the owner is high.
  - Memory outputs come from the request register.
  - Exactly one of `mem_memread` / `mem_memwrite` is high, per `we`, unless the error flag is set; then both are 0.
  - The store commits at the edge that ends ACCESS.
  - On a load, `mem_read_data` is captured into `rdata_q` at that same edge.
- RESP:
  - Owner's `mX_rvalid`=1.
  - `mX_rdata`=`rdata_q`, or 0 for a store or an error.
  - `mX_err`=error flag.
  - The non-owner's response outputs stay 0.
- Requester rule: drop `req` (or present a new request) in the cycle after seeing `gnt`. `req` during RESP is ignored and is re-evaluated in IDLE.
- Outside ACCESS, all `mem_*` outputs are 0.

## Timing
- Reset: FSM=IDLE, `last_owner`=1, `rdata_q`=0. All outputs are 0, including all `mem_*`, `gnt`, `rvalid`, `rdata`, `err` and `busy`.
- Reset asserted in ACCESS: `mem_memwrite` falls immediately and no store commits. No response is ever issued for the aborted request.
- Latency, with `req` high in IDLE cycle T:
  - `gnt` and memory access in T+1.
  - `rvalid` in T+2.
  - Next request can be sampled in T+3.
- Peak throughput: one access per 3 cycles.
- The losing requester keeps `req` high and is served in the next IDLE. Round-robin bounds its wait to one access (≤3 extra cycles).
- All outputs are registered or decoded from registered state. There is no combinational path from `mX_*` inputs to any output.
- `busy`=1 in ACCESS and RESP.

## Test plan
- Write then read on m0:
  - m0 SW addr 0x1000_0010, data 0xDEADBEEF → `m0_gnt` at T+1 with `mem_memwrite`=1, `mem_byte_size`=10; `m0_rvalid` at T+2 with `err`=0.
  - Then m0 LW at the same address → `m0_rdata`=0xDEADBEEF at T+2.
- Sign extension:
  - SB 0x80 at 0x1000_0021, then LB → 0xFFFFFF80.
  - LBU → 0x0000_0080.
  - LH at 0x1000_0020 with bytes 0x80/0x00 → 0xFFFF8000.
- Simultaneous requests:
  - m0 and m1 both assert from reset → grants in order m0, m1, m0, m1, spaced 3 cycles apart.
  - With `FIXED_PRIO`=1 → m0 every time while it requests.
- Error responses (each → `rvalid`+`err`=1, `rdata`=0, `mem_memread`=`mem_memwrite`=0 in ACCESS):
  - LW at 0x1000_0002.
  - SH at 0x1000_0001.
  - `size`=11.
  - Address 0x2000_0000.
- Reset mid-access:
  - Drop `reset_n` during ACCESS of SW 0x1000_0040 → `mem_memwrite` deasserts asynchronously, no `rvalid`, and a later LW returns the old value 0.
- `req` held through RESP:
  - m1 holds `req` for 6 cycles with the same fields → exactly two grants, at T+1 and T+4.
